// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipelined core's ID/EX stage.
//   N_DEF / R_DEF : default datapath and register-address widths
//   ex_ctrl_t     : control bundle carried in the EX slot
//   BUBBLE_CTRL   : control value of an inserted bubble (no side effects)
package pipeline_pkg;

  localparam int N_DEF = 24;
  localparam int R_DEF = 4;

  typedef struct packed {
    logic [3:0] aluControl;
    logic       immSrc;
    logic       branchFlag;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       valid;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_forward_unit.sv
// Combinational hazard detection and forwarding selection.
// Inputs : decode indices (dValid, dRs1, dRs2), branchTaken, EX-slot state
//          (exValid, exRegWrite, exMemRead, exRd, exRs1, exRs2) and MEM-shadow
//          state (memRd, memRegWrite, memMemRead).
// Outputs: stall (hold PC and IF/ID), Fa/Fb (forward EX/MEM ALU result to
//          operand A/B), flushD (invalidate IF/ID).
module hazard_forward_unit #(
  parameter int R = 4
) (
  input  logic         dValid,
  input  logic [R-1:0] dRs1,
  input  logic [R-1:0] dRs2,
  input  logic         branchTaken,
  input  logic         exValid,
  input  logic         exRegWrite,
  input  logic         exMemRead,
  input  logic [R-1:0] exRd,
  input  logic [R-1:0] exRs1,
  input  logic [R-1:0] exRs2,
  input  logic [R-1:0] memRd,
  input  logic         memRegWrite,
  input  logic         memMemRead,
  output logic         stall,
  output logic         Fa,
  output logic         Fb,
  output logic         flushD
);

  logic ex_load_hit;
  logic mem_load_hit;
  logic mem_alu_writer;

  always_comb begin
    // A load in EX or in MEM whose target is read by decode must hold decode
    // until the load data reaches writeback, where the capture bypass picks it up.
    ex_load_hit    = exMemRead & exRegWrite & ((exRd == dRs1) | (exRd == dRs2));
    mem_load_hit   = memMemRead & memRegWrite & ((memRd == dRs1) | (memRd == dRs2));
    // Loads are never forwarded from MEM: their data is not ready there.
    mem_alu_writer = memRegWrite & ~memMemRead;

    // A taken branch squashes decode anyway, so it overrides the stall.
    stall  = dValid & (ex_load_hit | mem_load_hit) & ~branchTaken;
    flushD = branchTaken;
    Fa     = exValid & mem_alu_writer & (memRd == exRs1);
    Fb     = exValid & mem_alu_writer & (memRd == exRs2);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard and forwarding control.
// Inputs : decode bundle (dValid, dRd1, dRd2, dPc, dImm, dAluControl, dImmSrc,
//          dBranchFlag, dRs1, dRs2, dRd, dRegWrite, dMemRead, dMemWrite),
//          branchTaken from execute, writeback port (wbRegWrite, wbRd, wbResult).
// Outputs: EX-slot operands/controls (rd1, rd2, pc, imm, aluControl, immSrc,
//          branchFlag, exValid, exRegWrite, exMemRead, exMemWrite, exRd),
//          forwarding selects Fa/Fb, stall and flushD.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dValid,
  input  logic [N-1:0] dRd1,
  input  logic [N-1:0] dRd2,
  input  logic [N-1:0] dPc,
  input  logic [N-1:0] dImm,
  input  logic [3:0]   dAluControl,
  input  logic         dImmSrc,
  input  logic         dBranchFlag,
  input  logic [R-1:0] dRs1,
  input  logic [R-1:0] dRs2,
  input  logic [R-1:0] dRd,
  input  logic         dRegWrite,
  input  logic         dMemRead,
  input  logic         dMemWrite,
  input  logic         branchTaken,
  input  logic         wbRegWrite,
  input  logic [R-1:0] wbRd,
  input  logic [N-1:0] wbResult,
  output logic [N-1:0] rd1,
  output logic [N-1:0] rd2,
  output logic [N-1:0] pc,
  output logic [N-1:0] imm,
  output logic [3:0]   aluControl,
  output logic         immSrc,
  output logic         branchFlag,
  output logic         Fa,
  output logic         Fb,
  output logic         exValid,
  output logic         exRegWrite,
  output logic         exMemRead,
  output logic         exMemWrite,
  output logic [R-1:0] exRd,
  output logic         stall,
  output logic         flushD
);

  ex_ctrl_t     ex_ctrl;
  ex_ctrl_t     ctrl_next;
  logic         bubble;
  logic [N-1:0] rd1_next;
  logic [N-1:0] rd2_next;
  logic [R-1:0] ex_rs1;
  logic [R-1:0] ex_rs2;
  logic [R-1:0] mem_rd;
  logic         mem_reg_write;
  logic         mem_mem_read;

  // NOTE: every variable written in always_comb gets a value on every path
  // (here unconditionally) so no latch is inferred.
  always_comb begin
    bubble    = branchTaken | stall | ~dValid;
    ctrl_next = '{aluControl: dAluControl, immSrc: dImmSrc, branchFlag: dBranchFlag,
                  regWrite: dRegWrite, memRead: dMemRead, memWrite: dMemWrite,
                  valid: 1'b1};
    // The register file write lands on this same edge, so decode's read data
    // is stale for a register being written back right now.
    rd1_next  = (wbRegWrite && (wbRd == dRs1)) ? wbResult : dRd1;
    rd2_next  = (wbRegWrite && (wbRd == dRs2)) ? wbResult : dRd2;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_ctrl       <= BUBBLE_CTRL;
      rd1           <= '0;
      rd2           <= '0;
      pc            <= '0;
      imm           <= '0;
      exRd          <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
    end else begin
      // MEM shadow follows the EX slot unconditionally so bubbles propagate.
      mem_rd        <= exRd;
      mem_reg_write <= ex_ctrl.regWrite;
      mem_mem_read  <= ex_ctrl.memRead;
      if (bubble) begin
        ex_ctrl <= BUBBLE_CTRL;
        rd1     <= '0;
        rd2     <= '0;
        pc      <= '0;
        imm     <= '0;
        exRd    <= '0;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
      end else begin
        ex_ctrl <= ctrl_next;
        rd1     <= rd1_next;
        rd2     <= rd2_next;
        pc      <= dPc;
        imm     <= dImm;
        exRd    <= dRd;
        ex_rs1  <= dRs1;
        ex_rs2  <= dRs2;
      end
    end
  end

  assign aluControl = ex_ctrl.aluControl;
  assign immSrc     = ex_ctrl.immSrc;
  assign branchFlag = ex_ctrl.branchFlag;
  assign exValid    = ex_ctrl.valid;
  assign exRegWrite = ex_ctrl.regWrite;
  assign exMemRead  = ex_ctrl.memRead;
  assign exMemWrite = ex_ctrl.memWrite;

  hazard_forward_unit #(.R(R)) u_hazard (
    .dValid      (dValid),
    .dRs1        (dRs1),
    .dRs2        (dRs2),
    .branchTaken (branchTaken),
    .exValid     (ex_ctrl.valid),
    .exRegWrite  (ex_ctrl.regWrite),
    .exMemRead   (ex_ctrl.memRead),
    .exRd        (exRd),
    .exRs1       (ex_rs1),
    .exRs2       (ex_rs2),
    .memRd       (mem_rd),
    .memRegWrite (mem_reg_write),
    .memMemRead  (mem_mem_read),
    .stall       (stall),
    .Fa          (Fa),
    .Fb          (Fb),
    .flushD      (flushD)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each stimulus cycle pushes the expected
// observation for that cycle; a monitor pops and compares on the falling edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        dValid;
  logic [23:0] dRd1, dRd2, dPc, dImm;
  logic [3:0]  dAluControl;
  logic        dImmSrc, dBranchFlag;
  logic [3:0]  dRs1, dRs2, dRd;
  logic        dRegWrite, dMemRead, dMemWrite;
  logic        branchTaken;
  logic        wbRegWrite;
  logic [3:0]  wbRd;
  logic [23:0] wbResult;
  logic [23:0] rd1, rd2, pc, imm;
  logic [3:0]  aluControl;
  logic        immSrc, branchFlag, Fa, Fb;
  logic        exValid, exRegWrite, exMemRead, exMemWrite;
  logic [3:0]  exRd;
  logic        stall, flushD;

  typedef struct {
    string       tag;
    logic        v, st, fa, fb, fl;
    bit          chk;
    logic [23:0] rd1, rd2, pc, imm;
    logic [3:0]  alu, rd;
    logic        rw, mr;
  } obs_t;

  obs_t q[$];
  int   total = 0;
  int   bad   = 0;

  id_ex_stage #(.N(24), .R(4)) dut (
    .clk(clk), .rst(rst), .dValid(dValid),
    .dRd1(dRd1), .dRd2(dRd2), .dPc(dPc), .dImm(dImm),
    .dAluControl(dAluControl), .dImmSrc(dImmSrc), .dBranchFlag(dBranchFlag),
    .dRs1(dRs1), .dRs2(dRs2), .dRd(dRd),
    .dRegWrite(dRegWrite), .dMemRead(dMemRead), .dMemWrite(dMemWrite),
    .branchTaken(branchTaken), .wbRegWrite(wbRegWrite), .wbRd(wbRd), .wbResult(wbResult),
    .rd1(rd1), .rd2(rd2), .pc(pc), .imm(imm), .aluControl(aluControl),
    .immSrc(immSrc), .branchFlag(branchFlag), .Fa(Fa), .Fb(Fb),
    .exValid(exValid), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exRd(exRd), .stall(stall), .flushD(flushD)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: one observation per falling edge while the scoreboard holds one.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      obs_t e;
      e = q.pop_front();
      check({e.tag, ".exValid"}, 24'(exValid), 24'(e.v));
      check({e.tag, ".stall"},   24'(stall),   24'(e.st));
      check({e.tag, ".Fa"},      24'(Fa),      24'(e.fa));
      check({e.tag, ".Fb"},      24'(Fb),      24'(e.fb));
      check({e.tag, ".flushD"},  24'(flushD),  24'(e.fl));
      if (e.chk) begin
        check({e.tag, ".rd1"},        rd1,              e.rd1);
        check({e.tag, ".rd2"},        rd2,              e.rd2);
        check({e.tag, ".pc"},         pc,               e.pc);
        check({e.tag, ".imm"},        imm,              e.imm);
        check({e.tag, ".aluControl"}, 24'(aluControl),  24'(e.alu));
        check({e.tag, ".exRd"},       24'(exRd),        24'(e.rd));
        check({e.tag, ".exRegWrite"}, 24'(exRegWrite),  24'(e.rw));
        check({e.tag, ".exMemRead"},  24'(exMemRead),   24'(e.mr));
      end
    end
  end

  task automatic expect_obs(input string tag, input logic v, st, fa, fb, fl);
    obs_t e;
    e.tag = tag; e.v = v; e.st = st; e.fa = fa; e.fb = fb; e.fl = fl;
    e.chk = 1'b0;
    e.rd1 = '0; e.rd2 = '0; e.pc = '0; e.imm = '0; e.alu = '0; e.rd = '0;
    e.rw = 1'b0; e.mr = 1'b0;
    q.push_back(e);
  endtask

  task automatic expect_full(input string tag, input logic v, st, fa, fb, fl,
                             input logic [23:0] e_rd1, e_rd2, e_pc, e_imm,
                             input logic [3:0] e_alu, e_rd, input logic e_rw, e_mr);
    obs_t e;
    e.tag = tag; e.v = v; e.st = st; e.fa = fa; e.fb = fb; e.fl = fl;
    e.chk = 1'b1;
    e.rd1 = e_rd1; e.rd2 = e_rd2; e.pc = e_pc; e.imm = e_imm; e.alu = e_alu;
    e.rd = e_rd; e.rw = e_rw; e.mr = e_mr;
    q.push_back(e);
  endtask

  task automatic dec(input logic [23:0] p, r1, r2, im, input logic [3:0] alu,
                     input logic [3:0] rs1, rs2, rd, input logic rw, mr);
    dValid = 1'b1; dPc = p; dRd1 = r1; dRd2 = r2; dImm = im; dAluControl = alu;
    dRs1 = rs1; dRs2 = rs2; dRd = rd; dRegWrite = rw; dMemRead = mr;
    dMemWrite = 1'b0; dImmSrc = 1'b0; dBranchFlag = 1'b0;
  endtask

  task automatic idle();
    dValid = 1'b0; dPc = '0; dRd1 = '0; dRd2 = '0; dImm = '0; dAluControl = '0;
    dRs1 = '0; dRs2 = '0; dRd = '0; dRegWrite = 1'b0; dMemRead = 1'b0;
    dMemWrite = 1'b0; dImmSrc = 1'b0; dBranchFlag = 1'b0; branchTaken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wbRegWrite = 1'b0; wbRd = '0; wbResult = '0;

    // Reset held with a valid bundle on the inputs and the clock running.
    dec(24'h000010, 24'h111111, 24'h222222, 24'h0, 4'h1, 4'd8, 4'd8, 4'd0, 1'b0, 1'b0);
    expect_full("reset", 0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 4'h0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;

    // First edge after release latches pc=0x10; drive pass-through bundle.
    step();
    dec(24'h000014, 24'h00ABCD, 24'h0000AA, 24'h000005, 4'h3, 4'd1, 4'd2, 4'd9, 1'b1, 1'b0);
    expect_full("first", 1, 0, 0, 0, 0, 24'h111111, 24'h222222, 24'h000010, 24'h0, 4'h1, 4'd0, 1'b0, 1'b0);

    // ALU writer to r5.
    step();
    dec(24'h000018, 24'h000011, 24'h000022, 24'h0, 4'h2, 4'd1, 4'd2, 4'd5, 1'b1, 1'b0);
    expect_full("pass", 1, 0, 0, 0, 0, 24'h00ABCD, 24'h0000AA, 24'h000014, 24'h000005, 4'h3, 4'd9, 1'b1, 1'b0);

    // Reader of r5 (rs1) and r7 (rs2).
    step();
    dec(24'h00001C, 24'h000100, 24'h000200, 24'h0, 4'h2, 4'd5, 4'd7, 4'd10, 1'b1, 1'b0);
    expect_full("writer", 1, 0, 0, 0, 0, 24'h000011, 24'h000022, 24'h000018, 24'h0, 4'h2, 4'd5, 1'b1, 1'b0);

    // Reader in EX, writer in MEM: Fa only. Decode a load to r3 (rs2=r10).
    step();
    dec(24'h000020, 24'h001000, 24'h0, 24'h000008, 4'h0, 4'd1, 4'd10, 4'd3, 1'b1, 1'b1);
    expect_full("fwd_a", 1, 0, 1, 0, 0, 24'h000100, 24'h000200, 24'h00001C, 24'h0, 4'h2, 4'd10, 1'b1, 1'b0);

    // Load in EX reads r10 just written by the reader in MEM: Fb.
    // Decode add using r3 directly behind the load: stall.
    step();
    dec(24'h000024, 24'h000001, 24'h999999, 24'h0, 4'h4, 4'd1, 4'd3, 4'd11, 1'b1, 1'b0);
    expect_full("fwd_b_stall1", 1, 1, 0, 1, 0, 24'h001000, 24'h0, 24'h000020, 24'h000008, 4'h0, 4'd3, 1'b1, 1'b1);

    // Load now in MEM (never forwarded): still stalled, bubble in EX.
    step();
    expect_full("stall2", 0, 1, 0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Load data at writeback as the add finally latches.
    step();
    wbRegWrite = 1'b1; wbRd = 4'd3; wbResult = 24'h123456;
    expect_full("stall_release", 0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Add in EX with rd2 captured from writeback. Decode load to r4.
    step();
    wbRegWrite = 1'b0; wbRd = '0; wbResult = '0;
    dec(24'h000028, 24'h0, 24'h0, 24'h000004, 4'h0, 4'd2, 4'd2, 4'd4, 1'b1, 1'b1);
    expect_full("wb_bypass", 1, 0, 0, 0, 0, 24'h000001, 24'h123456, 24'h000024, 24'h0, 4'h4, 4'd11, 1'b1, 1'b0);

    // Consumer of r4 behind the load while a branch is taken: flush wins.
    step();
    dec(24'h00002C, 24'h000777, 24'h000888, 24'h0, 4'h5, 4'd4, 4'd0, 4'd12, 1'b1, 1'b0);
    branchTaken = 1'b1;
    expect_full("flush", 1, 0, 0, 0, 1, 24'h0, 24'h0, 24'h000028, 24'h000004, 4'h0, 4'd4, 1'b1, 1'b1);

    // Flushed slot is a bubble; decode idle.
    step();
    idle();
    expect_full("post_flush", 0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 4'h0, 4'd0, 1'b0, 1'b0);

    // Load to r2.
    step();
    dec(24'h000030, 24'h0, 24'h0, 24'h000010, 4'h0, 4'd0, 4'd0, 4'd2, 1'b1, 1'b1);
    expect_obs("idle_bubble", 0, 0, 0, 0, 0);

    // Dependent consumer of r2: stall.
    step();
    dec(24'h000034, 24'h000AAA, 24'h000BBB, 24'h0, 4'h6, 4'd2, 4'd5, 4'd13, 1'b1, 1'b0);
    expect_full("pre_rst_stall", 1, 1, 0, 0, 0, 24'h0, 24'h0, 24'h000030, 24'h000010, 4'h0, 4'd2, 1'b1, 1'b1);

    // Still stalling (load in MEM); reset pulses between edges.
    step();
    #1 rst = 1'b1;
    expect_full("mid_rst", 0, 0, 0, 0, 0, 24'h0, 24'h0, 24'h0, 24'h0, 4'h0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Cleared state: consumer latches with no hazard.
    step();
    idle();
    expect_full("after_rst", 1, 0, 0, 0, 0, 24'h000AAA, 24'h000BBB, 24'h000034, 24'h0, 4'h6, 4'd13, 1'b1, 1'b0);

    step();
    expect_obs("drain", 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", 24'(q.size()), 24'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
